// File: rtl/seq_mul16.sv
// Sequential 16x16 signed radix-2 Booth multiplier driving an external adder.
// Optional SEQ_MUL16_OVFL_EN flags products that do not fit in 16-bit signed.
module seq_mul16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_sub,
    input  logic [15:0] add_s,
    input  logic        add_ovfl,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        ovfl
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] q_q, q_d;
    logic        qm1_q, qm1_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] prod_q, prod_d;

    logic [1:0]  booth_pair;
    logic        do_op;
    logic [15:0] sum_w;
    logic        top_w;

    assign booth_pair = {q_q[0], qm1_q};
    assign do_op      = booth_pair[1] ^ booth_pair[0];
    assign sum_w      = do_op ? add_s : acc_q;
    // Overflow-corrected sign keeps the shifted accumulator exact for M = -32768.
    assign top_w      = do_op ? (add_s[15] ^ add_ovfl) : acc_q[15];

    assign add_a   = acc_q;
    assign add_b   = m_q;
    assign add_sub = (state_q == S_RUN) && (booth_pair == 2'b10);
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_d     = a;
                    acc_d   = '0;
                    q_d     = b;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = {top_w, sum_w[15:1]};
                q_d   = {sum_w[0], q_q[15:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                    prod_d  = {acc_d, q_d};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

`ifdef SEQ_MUL16_OVFL_EN
    logic ovfl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_q <= 1'b0;
        end else if (state_q == S_RUN && state_d == S_DONE) begin
            ovfl_q <= !((&prod_d[31:15]) || !(|prod_d[31:15]));
        end
    end

    assign ovfl = ovfl_q;
`else
    assign ovfl = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mul16.sv
// Scoreboard bench for seq_mul16: directed vectors with hand-computed products,
// a behavioural external adder, and a monitor that checks every done pulse.
module tb_seq_mul16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic [15:0] add_s;
    logic        add_ovfl;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovfl;

`ifdef SEQ_MUL16_OVFL_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    typedef struct {
        logic [31:0] prod;
        logic        ov;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    seq_mul16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sub (add_sub),
        .add_s   (add_s),
        .add_ovfl(add_ovfl),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovfl    (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External adder: subtract is A + ~B + 1, with add_sub as the carry-in.
    logic [15:0] bb;
    logic [16:0] full;
    always_comb begin
        bb       = add_b ^ {16{add_sub}};
        full     = {1'b0, add_a} + {1'b0, bb} + {16'b0, add_sub};
        add_s    = full[15:0];
        add_ovfl = (add_a[15] == bb[15]) && (full[15] != add_a[15]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", product, e.prod);
                check("ovfl", {31'b0, ovfl}, {31'b0, e.ov});
                check("latency", cyc - e.acc_cyc, 16);
            end
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] ep, input logic eo, input bit push);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.prod    = ep;
        e.ov      = eo;
        e.acc_cyc = cyc;
        if (push) exp_q.push_back(e);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("add_a_cleared", {16'b0, add_a}, 32'd0);
        check("add_b_is_a", {16'b0, add_b}, {16'b0, ia});
        check("add_sub_first", {31'b0, add_sub}, {31'b0, ib[0]});
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_ovfl", {31'b0, ovfl}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'd3, 16'd4, 32'h0000000C, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("product_held", product, 32'h0000000C);

        issue(16'hFFFD, 16'd5, 32'hFFFFFFF1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        issue(16'h8000, 16'h8000, 32'h40000000, OV, 1'b1);
        wait_done();
        @(negedge clk);

        // Second start and operand changes mid-run must be ignored.
        issue(16'h7FFF, 16'h7FFF, 32'h3FFF0001, OV, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 16'd1;
        b     = 16'd1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
        check("busy_ignores_start", {31'b0, busy}, 32'd1);
        check("m_unchanged", {16'b0, add_b}, 32'h00007FFF);
        wait_done();

        // Back-to-back starts presented while done is high.
        issue(16'h1234, 16'h0010, 32'h00012340, OV, 1'b1);
        wait_done();
        issue(16'h8000, 16'h0001, 32'hFFFF8000, 1'b0, 1'b1);
        wait_done();
        issue(16'h7FFF, 16'h8000, 32'hC0008000, OV, 1'b1);
        wait_done();
        issue(16'h0000, 16'h1234, 32'h00000000, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(16'h7FFF, 16'h7FFF, 32'h3FFF0001, OV, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset mid-run abandons the operation.
        issue(16'd3, 16'd4, 32'h0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {31'b0, busy}, 32'd0);
        check("midrun_rst_done", {31'b0, done}, 32'd0);
        check("midrun_rst_product", product, 32'd0);
        check("midrun_rst_ovfl", {31'b0, ovfl}, 32'd0);
        check("midrun_rst_add_sub", {31'b0, add_sub}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", {31'b0, done}, 32'd0);

        issue(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
